// File: rtl/secuenciador_mux_dd.sv
// rtl/secuenciador_mux_dd.sv - data-block select sequencer: RTC init, master setup, date/time read sweeps with per-step timeout
module secuenciador_mux_dd #(
  parameter int TW      = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fin_I,
  input  logic       fin_MS,
  input  logic       fin_trans,
  input  logic       solicitud,
  output logic [3:0] Selec_Mux_DDw,
  output logic       ocupado,
  output logic       listo,
  output logic       error_to
);

  // The state encoding is the select code itself, so the output is a plain register.
  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_MS   = 4'd1,
    S_IDLE = 4'd2,
    S_DAY  = 4'd3,
    S_MON  = 4'd4,
    S_YEAR = 4'd5,
    S_HOUR = 4'd6,
    S_MIN  = 4'd7,
    S_SEC  = 4'd8
  } state_t;

  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_cnt;
  logic          r_pend;
  logic          r_listo;
  logic          r_err;

  logic w_term;
  logic w_to_fire;
  logic w_listo;
  logic w_start;
  logic w_cnt_clr;

  // Terminal count of the step timer; idle holds the counter at zero so it never fires there.
  assign w_term = (r_cnt == TERM);

  // Next-state decode: completion beats timeout when both land in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    w_listo   = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      S_INIT: begin
        if (fin_I) begin
          w_next = S_MS;
        end else if (w_term) begin
          w_next    = S_INIT;
          w_to_fire = 1'b1;
        end
      end
      S_MS: begin
        if (fin_MS) begin
          w_next = S_IDLE;
        end else if (w_term) begin
          w_next    = S_INIT;
          w_to_fire = 1'b1;
        end
      end
      S_IDLE: begin
        if (solicitud || r_pend) begin
          w_next  = S_DAY;
          w_start = 1'b1;
        end
      end
      S_DAY, S_MON, S_YEAR, S_HOUR, S_MIN, S_SEC: begin
        if (fin_trans) begin
          if (r_state == S_SEC) begin
            w_next  = S_IDLE;
            w_listo = 1'b1;
          end else begin
            w_next = state_t'(r_state + 4'd1);
          end
        end else if (w_term) begin
          w_next    = S_IDLE;
          w_to_fire = 1'b1;
        end
      end
      default: begin
        w_next = S_INIT;
      end
    endcase
  end

  // A timeout that stays in init must still restart the count, hence the extra clear term.
  assign w_cnt_clr = (w_next != r_state) || w_to_fire || (r_state == S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Per-step timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // Pending-request latch, sweep-done pulse and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_listo <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_listo <= w_listo;
      if (w_start) begin
        r_pend <= 1'b0;
      end else if (solicitud && (r_state != S_IDLE)) begin
        r_pend <= 1'b1;
      end
      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_to_fire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign Selec_Mux_DDw = r_state;
  assign ocupado       = (r_state != S_IDLE);
  assign listo         = r_listo;
  assign error_to      = r_err;

endmodule

// File: tb/tb_secuenciador_mux_dd.sv
// tb/tb_secuenciador_mux_dd.sv - scoreboard bench for secuenciador_mux_dd
module tb_secuenciador_mux_dd;

  logic       clk = 1'b0;
  logic       reset;
  logic       fin_I;
  logic       fin_MS;
  logic       fin_trans;
  logic       solicitud;
  logic [3:0] Selec_Mux_DDw;
  logic       ocupado;
  logic       listo;
  logic       error_to;

  secuenciador_mux_dd #(.TW(16), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .fin_I         (fin_I),
    .fin_MS        (fin_MS),
    .fin_trans     (fin_trans),
    .solicitud     (solicitud),
    .Selec_Mux_DDw (Selec_Mux_DDw),
    .ocupado       (ocupado),
    .listo         (listo),
    .error_to      (error_to)
  );

  always #5 clk = ~clk;

  // Expected code change: new code, listo and error_to on that cycle, edges since previous change (-1 = don't care).
  typedef struct packed {
    logic [3:0] code;
    logic       lst;
    logic       err;
    int         dwell;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc;
  int         last_chg = 0;
  logic [3:0] cur_code = 4'd0;
  logic       cur_err  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input logic lst, input logic err, input int dwell);
    exp_t e;
    e.code  = code;
    e.lst   = lst;
    e.err   = err;
    e.dwell = dwell;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input logic fi, input logic fms, input logic ft, input logic sol);
    fin_I     = fi;
    fin_MS    = fms;
    fin_trans = ft;
    solicitud = sol;
    tick(1);
    fin_I     = 1'b0;
    fin_MS    = 1'b0;
    fin_trans = 1'b0;
    solicitud = 1'b0;
  endtask

  // fin_trans lands gap edges after the current position; a change to code is expected there.
  task automatic advance(input int gap, input logic [3:0] code, input logic lst);
    push_exp(code, lst, 1'b0, gap);
    tick(gap - 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Edge counter restarted by reset so dwell times are counted from reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: pops an expectation whenever the select code moves, otherwise checks the outputs hold.
  always @(negedge clk) begin
    if (Selec_Mux_DDw !== cur_code) begin
      if (q.size() == 0) begin
        check("unexpected_code_change", int'(Selec_Mux_DDw), int'(cur_code));
        cur_code = Selec_Mux_DDw;
      end else begin
        mon_e = q.pop_front();
        check("code", int'(Selec_Mux_DDw), int'(mon_e.code));
        check("listo_at_change", int'(listo), int'(mon_e.lst));
        check("error_to_at_change", int'(error_to), int'(mon_e.err));
        check("ocupado_at_change", int'(ocupado), (mon_e.code != 4'd2) ? 1 : 0);
        if (mon_e.dwell >= 0) check("dwell_cycles", cyc - last_chg, mon_e.dwell);
        cur_code = mon_e.code;
        cur_err  = mon_e.err;
      end
      last_chg = cyc;
    end else begin
      check("listo_idle_low", int'(listo), 0);
      check("error_to_hold", int'(error_to), int'(cur_err));
      check("ocupado_hold", int'(ocupado), (cur_code != 4'd2) ? 1 : 0);
    end
    if (reset) last_chg = 0;
  end

  initial begin
    reset     = 1'b1;
    fin_I     = 1'b0;
    fin_MS    = 1'b0;
    fin_trans = 1'b0;
    solicitud = 1'b0;
    tick(2);
    check("reset_code", int'(Selec_Mux_DDw), 0);
    check("reset_ocupado", int'(ocupado), 1);
    check("reset_listo", int'(listo), 0);
    check("reset_error_to", int'(error_to), 0);
    reset = 1'b0;

    // Bring-up with stray fin_trans in 0000 and 0001: fin_I at cycle 3, fin_MS at cycle 6.
    push_exp(4'd1, 1'b0, 1'b0, 3);
    push_exp(4'd2, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Single request, six fin_trans four cycles apart.
    push_exp(4'd3, 1'b0, 1'b0, 3);
    tick(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 4; c <= 8; c++) advance(4, 4'(c), 1'b0);
    advance(4, 4'd2, 1'b1);

    // Requests during 0101 and 0110 merge into a single follow-up sweep.
    push_exp(4'd3, 1'b0, 1'b0, 3);
    tick(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    advance(4, 4'd4, 1'b0);
    advance(4, 4'd5, 1'b0);
    push_exp(4'd6, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(4'd7, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    advance(4, 4'd8, 1'b0);
    advance(4, 4'd2, 1'b1);
    push_exp(4'd3, 1'b0, 1'b0, 1);
    tick(1);
    for (int c = 4; c <= 8; c++) advance(4, 4'(c), 1'b0);
    advance(4, 4'd2, 1'b1);
    tick(6);

    // Timeout in 0100: forced to 0010 eight cycles after entry, flag sticky until next request.
    push_exp(4'd3, 1'b0, 1'b0, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    advance(4, 4'd4, 1'b0);
    push_exp(4'd2, 1'b0, 1'b1, 8);
    tick(12);
    push_exp(4'd3, 1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    advance(4, 4'd4, 1'b0);
    advance(4, 4'd5, 1'b0);
    advance(4, 4'd6, 1'b0);

    // fin_trans on the terminal-count cycle in 0110 wins over the timeout.
    advance(8, 4'd7, 1'b0);

    // Asynchronous reset in the middle of a cycle during 0111.
    tick(2);
    #1;
    push_exp(4'd0, 1'b0, 1'b0, -1);
    reset = 1'b1;
    #1;
    check("async_reset_code", int'(Selec_Mux_DDw), 0);
    check("async_reset_listo", int'(listo), 0);
    check("async_reset_ocupado", int'(ocupado), 1);
    check("async_reset_error_to", int'(error_to), 0);
    tick(2);
    reset = 1'b0;

    // Stray inputs after reset: fin_trans in 0000/0001, fin_I in 0011.
    push_exp(4'd1, 1'b0, 1'b0, 3);
    push_exp(4'd2, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(4'd3, 1'b0, 1'b0, 3);
    tick(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(4'd4, 1'b0, 1'b0, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 5; c <= 8; c++) advance(4, 4'(c), 1'b0);
    advance(4, 4'd2, 1'b1);
    tick(6);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_mux_dd.md
# secuenciador_mux_dd

Control-path sequencer that drives the 4-bit data-block select code `Selec_Mux_DDw` consumed by the data-block enable decoder. After reset it runs the RTC initialization and master-setup transactions once. It then idles, and on each read request walks the date (3 codes) and time (3 codes) transactions in order. Every step is held until the addressed block reports completion or a per-step timeout expires.

## Interface
Parameters:
- `TW`, 16: width of the per-step timeout counter.
- `TIMEOUT`, 1000: maximum cycles a step may wait for its completion input; legal range 2..2^TW-1.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fin_I`  in  1  single-cycle pulse: initialization transaction complete.
- `fin_MS`  in  1  single-cycle pulse: master-setup transaction complete.
- `fin_trans`  in  1  single-cycle pulse: current date/time register transaction complete.
- `solicitud`  in  1  read request; level or pulse, sampled each cycle.
- `Selec_Mux_DDw`  out  4  registered select code, 4'b0000..4'b1000.
- `ocupado`  out  1  high whenever the code is not 4'b0010.
- `listo`  out  1  one-cycle pulse when a full date/time sweep completes normally.
- `error_to`  out  1  sticky timeout flag; cleared when the next sweep starts.

## Operation
- Codes and meaning:
  - 0000: init.
  - 0001: master setup.
  - 0010: idle.
  - 0011, 0100, 0101: date fields (day, month, year).
  - 0110, 0111, 1000: time fields (hour, minute, second).
- Reset values: `Selec_Mux_DDw`=0000, `ocupado`=1, `listo`=0, `error_to`=0, timeout counter=0, pending-request latch=0.
- State transitions:
  - 0000 → 0001 on `fin_I`.
  - 0001 → 0010 on `fin_MS`.
  - 0010 → 0011 when `solicitud` or the pending latch is set; the latch clears and `error_to` clears on that edge.
  - 0011 → 0100 → … → 1000, each step advancing on `fin_trans`.
  - 1000 → 0010 on `fin_trans`, with `listo`=1 for that one cycle.
- Completion inputs not matching the current code are ignored:
  - `fin_I` outside 0000.
  - `fin_MS` outside 0001.
  - `fin_trans` in 0000, 0001 or 0010.
- Requests while busy: `solicitud` seen while code ≠ 0010 sets the one-deep pending latch. Further requests merge into it. It is serviced on the first idle cycle, so 0010 is held for exactly one cycle.
- Timeout behaviour:
  - The counter resets to 0 on every code change and increments each cycle otherwise.
  - If it reaches `TIMEOUT`-1 without the expected completion, the next edge forces the code to 0010 and sets `error_to`; `listo` is not pulsed.
  - A timeout in 0000 or 0001 returns to 0000, restarting init, instead of 0010.
  - In idle (0010) the counter is held at 0 and never times out.
- Simultaneous events: a completion input and the timeout terminal count in the same cycle resolve as completion, with no error.
- Codes 1001..1111 are unreachable. If ever present, the next edge forces 0000.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Completion sampled high at edge n → new code visible after edge n, i.e. one-cycle latency.
- `solicitud` sampled high at edge n while in 0010 → code 0011 after edge n.
- `listo` is high in the same cycle the code first reads 0010 after 1000.
- `ocupado` is derived from the registered code and changes in the same cycle as the code.
- Timeout: entry to a step at edge e with no completion → forced exit at edge e+`TIMEOUT`.
- `reset` asserted mid-sweep → immediately (asynchronously) 0000 with all outputs at reset values; the pending request is lost.

## Test plan
- Reset release with `fin_I` at cycle 3 and `fin_MS` at cycle 6:
  - codes 0000→0001 after cycle 3, 0001→0010 after cycle 6;
  - `ocupado` falls with the 0010 code.
- Single `solicitud` pulse, then six `fin_trans` pulses 4 cycles apart:
  - codes 0011,0100,0101,0110,0111,1000, then 0010;
  - `listo` high exactly one cycle; `error_to`=0.
- `solicitud` pulsed during code 0101:
  - after the sweep ends, 0010 for one cycle, then 0011 again;
  - a second pulse during the same sweep produces no extra sweep.
- `TIMEOUT`=8, no `fin_trans` in 0100:
  - code forced to 0010 exactly 8 cycles after entering 0100;
  - `error_to`=1 and stays set;
  - the next `solicitud` clears it on entry to 0011.
- `fin_trans` arrives on the timeout terminal cycle in 0110: advances to 0111 and `error_to` stays 0.
- Stray inputs and reset mid-sweep:
  - `fin_trans` pulses during 0000/0001 and `fin_I` during 0011 have no effect;
  - asserting `reset` mid-cycle during 0111 drives the code to 0000 immediately, with `listo`=0.
